hall_sequence_generator: RTL and testbench
==========================================

// Module: hall_sequence_generator
// PURPOSE
// Synthesises the six-state HALL sensor sequence of a rotating BLDC rotor from a commanded step period and direction.
// It drives hall_states_t codes into the encoder and commutation logic in place of physical sensors.
// Uses: sensorless/open-loop start-up, hardware-in-the-loop test, and bench stimulus for the HALL encoder.
// PARAMETERS
// clk_freq_hz    27_000_000  clock frequency in Hz (documentation and min_period derivation)
// counter_width  32          width of period, tick counter and position
// min_period     16          smallest legal step period in ticks; smaller nonzero requests are clamped up to it
// init_sector    0           sector (0..5) presented after reset
// PORTS
// clk            in   1              clock, rising edge
// reset_n        in   1              asynchronous, active-low reset
// cmd_valid      in   1              command handshake valid
// cmd_ready      out  1              command handshake ready
// cmd_period     in   counter_width  ticks per HALL step
// cmd_direction  in   rotation_direction_t  DIR_CW / DIR_CCW / DIR_NONE
// halt           in   1              level; immediate stop, overrides everything except reset
// fault_inject   in   1              see CONFIGURATION
// hall_values    out  hall_states_t  generated HALL code
// sector         out  3              sector of hall_values (0..5), 3'b111 when invalid
// step_strobe    out  1              1-cycle pulse on the cycle hall_values changes
// position       out  counter_width  signed step count: +1 per CW step, -1 per CCW step, two's-complement wrap
// running        out  1              high in RUN state
// BEHAVIOUR
// - Sector map (CW = increasing sector): 0 HALL_AC, 1 HALL_A, 2 HALL_AB, 3 HALL_B, 4 HALL_BC, 5 HALL_C.
//   CW steps 5->0 and CCW steps 0->5.
// - Reset values:
//   - cmd_ready 1, step_strobe 0, position 0, running 0.
//   - sector init_sector; hall_values is the code for init_sector.
//   - Internal: tick 0, pending empty, state IDLE.
// - All outputs are registered.
// - A command is accepted on an edge where cmd_valid & cmd_ready.
//   - cmd_ready = !pending_valid & !halt.
//   - A stop command is cmd_period==0 or cmd_direction==DIR_NONE.
// - State IDLE:
//   - Hall code is held; tick is held at 0.
//   - An accepted run command loads period and direction directly, enters RUN and clears tick.
//   - An accepted stop command is consumed with no effect.
// - State RUN:
//   - tick increments each cycle.
//   - When tick == period-1, a boundary occurs on that edge:
//     - sector steps +/-1 mod 6 and position steps +/-1, both using the current direction;
//     - step_strobe=1 and tick is cleared;
//     - if pending is valid, it is loaded into period/direction (or RUN->IDLE if it is a stop) and pending is cleared.
//   - A command accepted in RUN goes to the pending register and takes effect only at the next boundary.
//     cmd_ready drops the following cycle.
// - Latency:
//   - First hall change occurs exactly cmd_period edges after the accepting edge from IDLE.
//   - Following changes are spaced exactly cmd_period edges apart.
// - Simultaneous accept and boundary on one edge: the boundary uses the old settings; the new command is pending until the following boundary.
// - Halt:
//   - halt=1 forces IDLE on the next edge, clears pending and tick, and makes no step.
//   - hall_values, sector and position are held.
//   - halt together with cmd_valid means the command is not accepted (cmd_ready=0).
// - Period clamp: nonzero cmd_period < min_period is stored as min_period.
// - Reversal: a pending CW->CCW request produces the sequence ...3,4 (boundary) then 3, with position tracking +1 then -1.
//   No skipped or repeated code.
// - Reset mid-operation: all state returns to reset values asynchronously; any pending command is discarded.
// CONFIGURATION
// HALL_GEN_FAULT_INJECT_EN defined:
// - While fault_inject=1, hall_values is forced to the invalid code 3'b000, sector=3'b111 and step_strobe=0.
// - Internal tick, sector and position keep advancing.
// - On release, outputs show the current internal sector on the next edge.
// HALL_GEN_FAULT_INJECT_EN undefined: fault_inject is ignored and outputs are never forced invalid.
// TESTING
// 1. Reset, init_sector=0 -> hall_values=HALL_AC, sector=0, position=0, cmd_ready=1, running=0.
// 2. From IDLE, cmd period=100 DIR_CW -> first step at exactly 100 edges, then every 100.
//    Sectors 1,2,3,4,5,0; position=6 after 6 steps; step_strobe 1 cycle each.
// 3. In RUN at period=100, send CCW period=50 at tick 40 -> change at tick 99 still CW (+1).
//    cmd_ready low until then; next step 50 edges later is CCW; no sector skipped.
// 4. cmd period=5 (<min_period=16) -> steps spaced 16 edges.
//    Then a stop cmd (period=0) -> IDLE at the next boundary, hall held, running=0.
// 5. halt=1 mid-interval with a pending cmd -> next edge running=0, cmd_ready=0, pending dropped.
//    Hall and position unchanged; after halt=0, cmd_ready=1.
// 6. With HALL_GEN_FAULT_INJECT_EN: fault_inject pulse over one boundary -> hall 3'b000 and sector 7.
//    After release, sector equals internal sector+1 and position counted the hidden step.
//    Without the macro: output unaffected.

Source files
------------

// File: rtl/hall_sequence_generator.sv
// Six-state BLDC HALL sequence generator driven by a commanded step period and direction.
// Build macro HALL_GEN_FAULT_INJECT_EN enables forcing invalid HALL outputs through fault_inject.

package hall_gen_pkg;
    typedef enum logic [2:0] {
        HALL_INVALID = 3'b000,
        HALL_C       = 3'b001,
        HALL_B       = 3'b010,
        HALL_BC      = 3'b011,
        HALL_A       = 3'b100,
        HALL_AC      = 3'b101,
        HALL_AB      = 3'b110,
        HALL_ALL     = 3'b111
    } hall_states_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CW   = 2'b01,
        DIR_CCW  = 2'b10
    } rotation_direction_t;
endpackage

module hall_sequence_generator
    import hall_gen_pkg::*;
#(
    parameter int clk_freq_hz   = 27_000_000,
    parameter int counter_width = 32,
    parameter int min_period    = 16,
    parameter int init_sector   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [counter_width-1:0] cmd_period,
    input  rotation_direction_t      cmd_direction,
    input  logic                     halt,
    input  logic                     fault_inject,
    output hall_states_t             hall_values,
    output logic [2:0]               sector,
    output logic                     step_strobe,
    output logic [counter_width-1:0] position,
    output logic                     running
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // The clock frequency only documents how min_period was chosen.
    localparam int unused_clk_freq_hz = clk_freq_hz;
    localparam logic [2:0]               reset_sector = 3'(init_sector);
    localparam logic [counter_width-1:0] min_period_w = counter_width'(min_period);

    function automatic hall_states_t sector_to_hall(input logic [2:0] s);
        case (s)
            3'd0:    return HALL_AC;
            3'd1:    return HALL_A;
            3'd2:    return HALL_AB;
            3'd3:    return HALL_B;
            3'd4:    return HALL_BC;
            3'd5:    return HALL_C;
            default: return HALL_INVALID;
        endcase
    endfunction

    function automatic logic [2:0] step_sector(input logic [2:0] s, input rotation_direction_t d);
        logic [2:0] r;
        r = s;
        if (d == DIR_CW) begin
            r = (s == 3'd5) ? 3'd0 : s + 3'd1;
        end else if (d == DIR_CCW) begin
            r = (s == 3'd0) ? 3'd5 : s - 3'd1;
        end
        return r;
    endfunction

    state_t                   state;
    logic [counter_width-1:0] tick;
    logic [counter_width-1:0] period;
    rotation_direction_t      direction;
    logic                     pend_valid;
    logic                     pend_stop;
    logic [counter_width-1:0] pend_period;
    rotation_direction_t      pend_direction;
    logic [2:0]               int_sector;

    logic                     accept;
    logic                     cmd_is_stop;
    logic                     boundary;
    logic                     pend_valid_nxt;
    logic [counter_width-1:0] cmd_period_clamped;
    logic [2:0]               sector_nxt;
    logic                     force_invalid;

    assign accept             = cmd_valid & cmd_ready & ~halt;
    assign cmd_is_stop        = (cmd_period == '0) || (cmd_direction == DIR_NONE);
    assign cmd_period_clamped = (cmd_period < min_period_w) ? min_period_w : cmd_period;
    assign boundary           = (state == RUN) && (tick == period - 1'b1) && !halt;
    assign sector_nxt         = boundary ? step_sector(int_sector, direction) : int_sector;

`ifdef HALL_GEN_FAULT_INJECT_EN
    assign force_invalid = fault_inject;
`else
    logic unused_fault_inject;
    assign unused_fault_inject = fault_inject;
    assign force_invalid       = 1'b0;
`endif

    // An accept in RUN wins over a same-edge boundary so the new command stays pending.
    always_comb begin
        pend_valid_nxt = pend_valid;
        if (halt) begin
            pend_valid_nxt = 1'b0;
        end else if ((state == RUN) && accept) begin
            pend_valid_nxt = 1'b1;
        end else if (boundary) begin
            pend_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tick           <= '0;
            period         <= min_period_w;
            direction      <= DIR_NONE;
            pend_valid     <= 1'b0;
            pend_stop      <= 1'b0;
            pend_period    <= '0;
            pend_direction <= DIR_NONE;
            int_sector     <= reset_sector;
            position       <= '0;
            running        <= 1'b0;
            cmd_ready      <= 1'b1;
            step_strobe    <= 1'b0;
            sector         <= reset_sector;
            hall_values    <= sector_to_hall(reset_sector);
        end else begin
            if (halt) begin
                state   <= IDLE;
                tick    <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tick <= '0;
                        if (accept && !cmd_is_stop) begin
                            period    <= cmd_period_clamped;
                            direction <= cmd_direction;
                            state     <= RUN;
                            running   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (boundary) begin
                            tick       <= '0;
                            int_sector <= sector_nxt;
                            position   <= (direction == DIR_CW) ? position + 1'b1
                                                                : position - 1'b1;
                            if (pend_valid) begin
                                if (pend_stop) begin
                                    state   <= IDLE;
                                    running <= 1'b0;
                                end else begin
                                    period    <= pend_period;
                                    direction <= pend_direction;
                                end
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                        if (accept) begin
                            pend_stop      <= cmd_is_stop;
                            pend_period    <= cmd_period_clamped;
                            pend_direction <= cmd_direction;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            pend_valid <= pend_valid_nxt;
            cmd_ready  <= !pend_valid_nxt && !halt;

            // Internal stepping continues underneath a forced-invalid output.
            if (force_invalid) begin
                hall_values <= HALL_INVALID;
                sector      <= 3'b111;
                step_strobe <= 1'b0;
            end else begin
                hall_values <= sector_to_hall(sector_nxt);
                sector      <= sector_nxt;
                step_strobe <= boundary;
            end
        end
    end

endmodule

// File: tb/tb_hall_sequence_generator.sv
// Directed self-checking bench for hall_sequence_generator (default parameters, init_sector 0).
// Expectations are hand-derived from the step timing: first step cmd_period edges after accept.

module tb_hall_sequence_generator;
    import hall_gen_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [31:0]         cmd_period = 32'd0;
    rotation_direction_t cmd_direction = DIR_NONE;
    logic                halt = 1'b0;
    logic                fault_inject = 1'b0;
    hall_states_t        hall_values;
    logic [2:0]          sector;
    logic                step_strobe;
    logic [31:0]         position;
    logic                running;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    hall_sequence_generator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_period   (cmd_period),
        .cmd_direction(cmd_direction),
        .halt         (halt),
        .fault_inject (fault_inject),
        .hall_values  (hall_values),
        .sector       (sector),
        .step_strobe  (step_strobe),
        .position     (position),
        .running      (running)
    );

    function automatic hall_states_t hall_of(input logic [2:0] s);
        case (s)
            3'd0:    return HALL_AC;
            3'd1:    return HALL_A;
            3'd2:    return HALL_AB;
            3'd3:    return HALL_B;
            3'd4:    return HALL_BC;
            3'd5:    return HALL_C;
            default: return HALL_INVALID;
        endcase
    endfunction

    task automatic wait_edges(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [31:0] p, input rotation_direction_t d);
        cmd_valid     = 1'b1;
        cmd_period    = p;
        cmd_direction = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!step_strobe && n < 1000);
        if (!step_strobe) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL wait_step: no step_strobe within %0d edges", n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_compared++;
        if (hall_values !== HALL_AC || sector !== 3'd0 || position !== 32'd0 ||
            cmd_ready !== 1'b1 || running !== 1'b0 || step_strobe !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: hall=%b sector=%0d pos=%0d ready=%b run=%b strobe=%b, required hall=101 sector=0 pos=0 ready=1 run=0 strobe=0",
                     hall_values, sector, position, cmd_ready, running, step_strobe);
        end
        reset_n = 1'b1;
        wait_edges(2);
        n_compared++;
        if (sector !== 3'd0 || running !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: sector=%0d run=%b, required 0/0", sector, running);
        end
    endtask

    task automatic test_cw_run();
        int n;
        logic [2:0] exp_s;
        send_cmd(32'd100, DIR_CW);
        for (int k = 1; k <= 6; k++) begin
            wait_step(n);
            exp_s = 3'(k % 6);
            n_compared++;
            if (n !== 100) begin
                n_mismatched++;
                $display("[TB] FAIL cw_spacing step %0d: got %0d edges, required 100", k, n);
            end
            n_compared++;
            if (sector !== exp_s || hall_values !== hall_of(exp_s)) begin
                n_mismatched++;
                $display("[TB] FAIL cw_sector step %0d: sector=%0d hall=%b, required sector=%0d", k, sector, hall_values, exp_s);
            end
        end
        n_compared++;
        if (position !== 32'd6 || running !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL cw_position: pos=%0d run=%b, required 6/1", position, running);
        end
    endtask

    task automatic test_reversal();
        int n;
        wait_edges(40);
        send_cmd(32'd50, DIR_CCW);
        n_compared++;
        if (cmd_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rev_ready_low: ready=%b, required 0", cmd_ready);
        end
        wait_step(n);
        n_compared++;
        if (n !== 59 || sector !== 3'd1 || position !== 32'd7 || cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rev_old_step: edges=%0d sector=%0d pos=%0d ready=%b, required 59/1/7/1", n, sector, position, cmd_ready);
        end
        wait_step(n);
        n_compared++;
        if (n !== 50 || sector !== 3'd0 || position !== 32'd6) begin
            n_mismatched++;
            $display("[TB] FAIL rev_new_step: edges=%0d sector=%0d pos=%0d, required 50/0/6", n, sector, position);
        end
    endtask

    task automatic test_back_to_back_clamp();
        int n;
        wait_edges(49);
        send_cmd(32'd5, DIR_CW);
        n_compared++;
        if (step_strobe !== 1'b1 || sector !== 3'd5 || position !== 32'd5 || cmd_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL same_edge_step: strobe=%b sector=%0d pos=%0d ready=%b, required 1/5/5/0", step_strobe, sector, position, cmd_ready);
        end
        wait_step(n);
        n_compared++;
        if (n !== 50 || sector !== 3'd4 || position !== 32'd4) begin
            n_mismatched++;
            $display("[TB] FAIL pending_old_step: edges=%0d sector=%0d pos=%0d, required 50/4/4", n, sector, position);
        end
        wait_step(n);
        n_compared++;
        if (n !== 16 || sector !== 3'd5 || position !== 32'd5) begin
            n_mismatched++;
            $display("[TB] FAIL clamp_step1: edges=%0d sector=%0d pos=%0d, required 16/5/5", n, sector, position);
        end
        wait_step(n);
        n_compared++;
        if (n !== 16 || sector !== 3'd0 || position !== 32'd6) begin
            n_mismatched++;
            $display("[TB] FAIL clamp_step2: edges=%0d sector=%0d pos=%0d, required 16/0/6", n, sector, position);
        end
    endtask

    task automatic test_stop();
        int n;
        int strobes;
        send_cmd(32'd0, DIR_CW);
        wait_step(n);
        n_compared++;
        if (n !== 15 || sector !== 3'd1 || position !== 32'd7 || running !== 1'b0 || cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stop_boundary: edges=%0d sector=%0d pos=%0d run=%b ready=%b, required 15/1/7/0/1",
                     n, sector, position, running, cmd_ready);
        end
        strobes = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (step_strobe) strobes++;
        end
        n_compared++;
        if (strobes !== 0 || sector !== 3'd1 || hall_values !== HALL_A) begin
            n_mismatched++;
            $display("[TB] FAIL stop_hold: strobes=%0d sector=%0d hall=%b, required 0/1/100", strobes, sector, hall_values);
        end
    endtask

    task automatic test_halt();
        int strobes;
        send_cmd(32'd100, DIR_CW);
        wait_edges(30);
        send_cmd(32'd40, DIR_CCW);
        n_compared++;
        if (cmd_ready !== 1'b0 || running !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL halt_setup: ready=%b run=%b, required 0/1", cmd_ready, running);
        end
        halt = 1'b1;
        wait_edges(1);
        n_compared++;
        if (running !== 1'b0 || cmd_ready !== 1'b0 || sector !== 3'd1 || position !== 32'd7) begin
            n_mismatched++;
            $display("[TB] FAIL halt_stop: run=%b ready=%b sector=%0d pos=%0d, required 0/0/1/7", running, cmd_ready, sector, position);
        end
        halt = 1'b0;
        wait_edges(1);
        n_compared++;
        if (cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL halt_release_ready: ready=%b, required 1", cmd_ready);
        end
        halt          = 1'b1;
        cmd_valid     = 1'b1;
        cmd_period    = 32'd20;
        cmd_direction = DIR_CW;
        wait_edges(1);
        n_compared++;
        if (running !== 1'b0 || cmd_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL halt_blocks_cmd: run=%b ready=%b, required 0/0", running, cmd_ready);
        end
        halt      = 1'b0;
        cmd_valid = 1'b0;
        strobes   = 0;
        for (int j = 0; j < 120; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (step_strobe) strobes++;
        end
        n_compared++;
        if (strobes !== 0 || running !== 1'b0 || sector !== 3'd1 || position !== 32'd7 || cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL halt_pending_dropped: strobes=%0d run=%b sector=%0d pos=%0d ready=%b, required 0/0/1/7/1",
                     strobes, running, sector, position, cmd_ready);
        end
    endtask

    task automatic test_fault_inject();
        int bad;
        send_cmd(32'd20, DIR_CW);
        wait_edges(10);
        fault_inject = 1'b1;
        bad = 0;
        for (int j = 11; j <= 25; j++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef HALL_GEN_FAULT_INJECT_EN
            if (hall_values !== HALL_INVALID || sector !== 3'b111 || step_strobe !== 1'b0) bad++;
`else
            if (sector !== ((j >= 20) ? 3'd2 : 3'd1) || step_strobe !== (j == 20)) bad++;
`endif
        end
        n_compared++;
        if (bad !== 0 || position !== 32'd8) begin
            n_mismatched++;
            $display("[TB] FAIL fault_window: bad_cycles=%0d pos=%0d, required 0/8", bad, position);
        end
        fault_inject = 1'b0;
        wait_edges(1);
        n_compared++;
        if (sector !== 3'd2 || hall_values !== HALL_AB || position !== 32'd8) begin
            n_mismatched++;
            $display("[TB] FAIL fault_release: sector=%0d hall=%b pos=%0d, required 2/110/8", sector, hall_values, position);
        end
        halt = 1'b1;
        wait_edges(1);
        halt = 1'b0;
        wait_edges(1);
    endtask

    task automatic test_reset_mid();
        int strobes;
        send_cmd(32'd20, DIR_CW);
        wait_edges(5);
        send_cmd(32'd30, DIR_CCW);
        #2 reset_n = 1'b0;
        #1;
        n_compared++;
        if (sector !== 3'd0 || hall_values !== HALL_AC || position !== 32'd0 ||
            running !== 1'b0 || cmd_ready !== 1'b1 || step_strobe !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: sector=%0d hall=%b pos=%0d run=%b ready=%b strobe=%b, required 0/101/0/0/1/0",
                     sector, hall_values, position, running, cmd_ready, step_strobe);
        end
        @(negedge clk);
        reset_n = 1'b1;
        strobes = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (step_strobe) strobes++;
        end
        n_compared++;
        if (strobes !== 0 || running !== 1'b0 || sector !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_discards_pending: strobes=%0d run=%b sector=%0d, required 0/0/0", strobes, running, sector);
        end
    endtask

    initial begin
        test_reset();
        test_cw_run();
        test_reversal();
        test_back_to_back_clamp();
        test_stop();
        test_halt();
        test_fault_inject();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
